fifo_ptr_ctrl: RTL
==================

# fifo_ptr_ctrl

Parametrised pointer/status controller for one side of a dual-clock MAC FIFO. Holds the local binary and Gray pointers, synchronises the remote Gray pointer into the local clock, and produces registered full/empty, fill level, almost-threshold and overflow/underflow indications. Two instances, one with MODE=0 (write side) and one with MODE=1 (read side), plus a dual-port RAM form a complete asynchronous FIFO.

## Interface
- ADDRWIDTH, 6: RAM address width; depth = 2^ADDRWIDTH; minimum 2.
- MODE, 0: 0 = write side (full/almostFull), 1 = read side (empty/almostEmpty).
- SYNC_STAGES, 2: remote pointer synchroniser depth; minimum 2.
- clk  in  1  local clock; single clock domain.
- hardReset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of local pointers and status.
- incEn  in  1  push (MODE=0) or pop (MODE=1) request.
- incDisable  in  1  blocks the increment when high. No error is raised.
- threshold  in  ADDRWIDTH+1  almost-flag level threshold. Quasi-static.
- remotePtrGray  in  ADDRWIDTH+1  Gray pointer from the other clock domain.
- ptrAddr  out  ADDRWIDTH  RAM address, equal to ptrBin[ADDRWIDTH-1:0].
- ptrBin  out  ADDRWIDTH+1  local binary pointer.
- ptrGray  out  ADDRWIDTH+1  local Gray pointer, registered, sent to the remote side.
- status  out  1  full (MODE=0) or empty (MODE=1).
- almost  out  1  almostFull (level >= threshold) or almostEmpty (level <= threshold).
- level  out  ADDRWIDTH+1  fill level as seen from this side.
- error  out  1  one-cycle pulse on overflow (MODE=0) or underflow (MODE=1).

## Operation
- accept = incEn & ~incDisable & ~status & ~flush.
- On accept, nextBin = ptrBin + 1, modulo 2^(ADDRWIDTH+1), and nextGray = nextBin ^ (nextBin >> 1).
- If incEn & ~incDisable & status & ~flush, the pointer holds and error pulses for one cycle.
- The remote pointer passes through SYNC_STAGES flops to give rSync. rBin = gray2Binary(rSync).
- Status, level and almost are registered and computed from nextGray/nextBin and rSync/rBin. They therefore update on the same edge as the pointer.
- Full (MODE=0): nextGray == {~rSync[A:A-1], rSync[A-2:0]}, where A = ADDRWIDTH.
- Empty (MODE=1): nextGray == rSync.
- Level (MODE=0): nextBin - rBin, modulo 2^(A+1).
- Level (MODE=1): rBin - nextBin, modulo 2^(A+1).
- Level ranges from 0 to 2^A inclusive and never exceeds 2^A.
- Priority: hardReset > flush > accept/error > hold.
- Flush sets ptrBin, ptrGray and level to 0, and sets status and almost to their reset values. Error is 0 while flush is asserted.
- Flush does not clear the synchroniser. The remote side is flushed independently by system control.
- Status is re-evaluated on the first edge after flush falls.

## Timing
- Reset values: ptrBin, ptrAddr, ptrGray, level, error and all synchroniser flops are 0.
- Reset values for MODE=0: status = 0, almost = (threshold == 0).
- Reset values for MODE=1: status = 1, almost = 1.
- Latency: accept at edge N updates ptrBin, ptrGray, status, level and almost after edge N.
- Back-to-back accepts are allowed every cycle.
- A remote Gray change at edge N is reflected in status, level and almost after edge N+SYNC_STAGES.
- Flags are conservative: status may assert late in releasing (pessimistic), but never falsely deasserts.
- Wrap-around: ptrBin goes from 2^(A+1)-1 to 0 with ptrGray changing by exactly one bit.
- hardReset mid-operation forces all outputs to reset values asynchronously. Release is assumed synchronised upstream.

## Structure
- Package fifo_ptr_pkg holds the binary2Gray and gray2Binary functions, parametrised by width, and the constants MODE_WR = 0 and MODE_RD = 1.
- Sub-module fifo_gray_sync: multi-bit SYNC_STAGES flop chain with async active-high reset. Reused by other CDC paths.
- Everything else is a single always block per register group. No state machine beyond the pointer registers.

## Test plan
- MODE=0, ADDRWIDTH=2, remotePtrGray=0: 4 accepted pushes -> ptrGray=3'b110, level=4, status=1. 5th push -> error pulses one cycle and ptrBin stays 4.
- MODE=1, ADDRWIDTH=2, SYNC_STAGES=2: from reset, status=1. Drive remotePtrGray=3'b011 -> status falls and level=2 two edges later. Two pops -> status=1, level=0.
- Wrap-around: paired instances, 8 push/pop pairs -> ptrBin goes 7 -> 0, ptrGray goes 3'b100 -> 3'b000, and every ptrGray transition is single-bit.
- Simultaneous flush and incEn with level=3 -> after the edge, ptrBin=0, level=0 and error=0.
- hardReset asserted mid-burst, asynchronously between edges -> outputs reach reset values immediately. Normal pushes resume after release.
- threshold=3, MODE=0 -> almost rises on the 3rd accepted push and falls when rBin advances level to 2.

Source files
------------

// File: rtl/fifo_ptr_pkg.sv
// Gray/binary conversion helpers and side-select constants for the async FIFO pointer controllers.
// Functions work on zero-extended values up to PTR_MAX_W bits, so callers cast to their own width.
package fifo_ptr_pkg;

  localparam int MODE_WR   = 0;
  localparam int MODE_RD   = 1;
  localparam int PTR_MAX_W = 32;

  function automatic logic [PTR_MAX_W-1:0] binary2Gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Leading zeros of a zero-extended Gray value decode to zeros, so any width up to PTR_MAX_W works.
  function automatic logic [PTR_MAX_W-1:0] gray2Binary(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// Multi-bit flop chain for bringing a Gray-coded value into the local clock domain.
// Latency STAGES cycles; no backpressure, samples every cycle.
module fifo_gray_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             hardReset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or posedge hardReset) begin
    if (hardReset) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// One side of an async FIFO: local binary/Gray pointer, remote pointer sync, registered full/empty, level, almost, error.
// Latency: pointer and flags update on the accepting edge; blocked requests (full/empty) pulse error instead.
module fifo_ptr_ctrl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRWIDTH   = 6,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 hardReset,
  input  logic                 flush,
  input  logic                 incEn,
  input  logic                 incDisable,
  input  logic [ADDRWIDTH:0]   threshold,
  input  logic [ADDRWIDTH:0]   remotePtrGray,
  output logic [ADDRWIDTH-1:0] ptrAddr,
  output logic [ADDRWIDTH:0]   ptrBin,
  output logic [ADDRWIDTH:0]   ptrGray,
  output logic                 status,
  output logic                 almost,
  output logic [ADDRWIDTH:0]   level,
  output logic                 error
);

  localparam int                 PW           = ADDRWIDTH + 1;
  localparam logic [ADDRWIDTH:0] PTR_ONE      = {{ADDRWIDTH{1'b0}}, 1'b1};
  localparam logic               RESET_STATUS = (MODE == MODE_RD);

  logic [ADDRWIDTH:0] rSync;
  logic [ADDRWIDTH:0] rBin;
  logic [ADDRWIDTH:0] nextBin;
  logic [ADDRWIDTH:0] nextGray;
  logic [ADDRWIDTH:0] nextLevel;
  logic [ADDRWIDTH:0] fullGray;
  logic               req;
  logic               accept;
  logic               nextStatus;
  logic               nextAlmost;
  logic               resetAlmost;

  fifo_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .hardReset (hardReset),
    .d         (remotePtrGray),
    .q         (rSync)
  );

  always_comb begin
    req      = incEn & ~incDisable & ~flush;
    accept   = req & ~status;
    nextBin  = accept ? (ptrBin + PTR_ONE) : ptrBin;
    nextGray = PW'(binary2Gray(PTR_MAX_W'(nextBin)));
    rBin     = PW'(gray2Binary(PTR_MAX_W'(rSync)));
    // Full when the remote pointer is exactly one lap behind: top two Gray bits inverted.
    fullGray = {~rSync[ADDRWIDTH:ADDRWIDTH-1], rSync[ADDRWIDTH-2:0]};
    if (MODE == MODE_WR) begin
      nextStatus  = (nextGray == fullGray);
      nextLevel   = nextBin - rBin;
      nextAlmost  = (nextLevel >= threshold);
      resetAlmost = (threshold == '0);
    end else begin
      nextStatus  = (nextGray == rSync);
      nextLevel   = rBin - nextBin;
      nextAlmost  = (nextLevel <= threshold);
      resetAlmost = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge hardReset) begin
    if (hardReset) begin
      ptrBin  <= '0;
      ptrGray <= '0;
    end else if (flush) begin
      ptrBin  <= '0;
      ptrGray <= '0;
    end else if (accept) begin
      ptrBin  <= nextBin;
      ptrGray <= nextGray;
    end
  end

  always_ff @(posedge clk or posedge hardReset) begin
    if (hardReset) begin
      status <= RESET_STATUS;
      almost <= resetAlmost;
      level  <= '0;
    end else if (flush) begin
      status <= RESET_STATUS;
      almost <= resetAlmost;
      level  <= '0;
    end else begin
      status <= nextStatus;
      almost <= nextAlmost;
      level  <= nextLevel;
    end
  end

  always_ff @(posedge clk or posedge hardReset) begin
    if (hardReset) begin
      error <= 1'b0;
    end else begin
      error <= req & status;
    end
  end

  assign ptrAddr = ptrBin[ADDRWIDTH-1:0];

endmodule
